// File: rtl/ps2_keys_pkg.sv
// ps2_keys_pkg
// Shared constants for the PS/2 set-2 key decoder: prefix and ignorable
// byte values, game-key scan codes, bit positions within the keys vector,
// and the decoder state encoding.
package ps2_keys_pkg;

  // Prefixes and keyboard status / response bytes
  localparam logic [7:0] SC_E0 = 8'hE0;  // extended prefix
  localparam logic [7:0] SC_F0 = 8'hF0;  // break prefix
  localparam logic [7:0] SC_E1 = 8'hE1;  // pause sequence prefix
  localparam logic [7:0] SC_AA = 8'hAA;  // self-test passed
  localparam logic [7:0] SC_FA = 8'hFA;  // acknowledge
  localparam logic [7:0] SC_FE = 8'hFE;  // resend request
  localparam logic [7:0] SC_EE = 8'hEE;  // echo
  localparam logic [7:0] SC_00 = 8'h00;  // buffer overrun / error
  localparam logic [7:0] SC_FF = 8'hFF;  // buffer overrun / error

  // Fake shift codes emitted around extended keys (dropped after E0 / E0 F0)
  localparam logic [7:0] SC_FAKE_LSHIFT = 8'h12;
  localparam logic [7:0] SC_FAKE_RSHIFT = 8'h59;

  // Game key scan codes: extended (arrows) and non-extended bindings
  localparam logic [7:0] SC_ARROW_LEFT  = 8'h6B;
  localparam logic [7:0] SC_ARROW_RIGHT = 8'h74;
  localparam logic [7:0] SC_ARROW_UP    = 8'h75;
  localparam logic [7:0] SC_ARROW_DOWN  = 8'h72;
  localparam logic [7:0] SC_A           = 8'h1C;
  localparam logic [7:0] SC_D           = 8'h23;
  localparam logic [7:0] SC_W           = 8'h1D;
  localparam logic [7:0] SC_S           = 8'h1B;
  localparam logic [7:0] SC_SPACE       = 8'h29;
  localparam logic [7:0] SC_LCTRL       = 8'h14;
  localparam logic [7:0] SC_ENTER       = 8'h5A;
  localparam logic [7:0] SC_ESC         = 8'h76;

  // Bit positions in the keys vector
  localparam logic [2:0] KEY_LEFT  = 3'd0;
  localparam logic [2:0] KEY_RIGHT = 3'd1;
  localparam logic [2:0] KEY_UP    = 3'd2;
  localparam logic [2:0] KEY_DOWN  = 3'd3;
  localparam logic [2:0] KEY_JUMP  = 3'd4;
  localparam logic [2:0] KEY_FIRE  = 3'd5;
  localparam logic [2:0] KEY_ENTER = 3'd6;
  localparam logic [2:0] KEY_ESC   = 3'd7;

  // Bytes still to swallow after E1 (E1 14 77 E1 F0 14 F0 77)
  localparam logic [2:0] SKIP_LEN = 3'd7;

  typedef enum logic [2:0] {
    ST_IDLE   = 3'd0,
    ST_EXT    = 3'd1,
    ST_BRK    = 3'd2,
    ST_EXTBRK = 3'd3,
    ST_SKIP   = 3'd4
  } state_t;

  // Bytes that never start or complete a key event when seen in IDLE
  function automatic logic is_ignored(input logic [7:0] b);
    return (b == SC_AA) || (b == SC_FA) || (b == SC_FE) ||
           (b == SC_EE) || (b == SC_00) || (b == SC_FF);
  endfunction

  function automatic logic is_fake_shift(input logic [7:0] b);
    return (b == SC_FAKE_LSHIFT) || (b == SC_FAKE_RSHIFT);
  endfunction

endpackage

// File: rtl/ps2_key_decoder_if.sv
// ps2_key_decoder_if
// Bundles the receiver byte stream feeding the decoder and the decoder's
// key/event outputs.
//   ready_in, data_in : byte stream from the PS/2 receiver
//   keys              : registered pressed-key vector
//   ev_*              : key event strobe and its attributes
// Modports: master = byte source / event consumer, slave = decoder.
interface ps2_key_decoder_if;
  logic       ready_in;
  logic [7:0] data_in;
  logic [7:0] keys;
  logic       ev_valid;
  logic [7:0] ev_code;
  logic       ev_ext;
  logic       ev_break;
  logic       ev_repeat;

  modport master (
    output ready_in, data_in,
    input  keys, ev_valid, ev_code, ev_ext, ev_break, ev_repeat
  );

  modport slave (
    input  ready_in, data_in,
    output keys, ev_valid, ev_code, ev_ext, ev_break, ev_repeat
  );
endinterface

// File: rtl/ps2_keymap.sv
// ps2_keymap
// Combinational lookup from (extended flag, scan code) to a keys-vector bit.
//   ext  in  1 : code was E0-prefixed
//   code in  8 : final scan-code byte
//   hit  out 1 : code is bound to a game key
//   idx  out 3 : keys bit index (valid when hit)
module ps2_keymap
  import ps2_keys_pkg::*;
(
  input  logic       ext,
  input  logic [7:0] code,
  output logic       hit,
  output logic [2:0] idx
);

  always_comb begin
    hit = 1'b0;
    idx = 3'd0;
    if (ext) begin
      unique case (code)
        SC_ARROW_LEFT:  begin hit = 1'b1; idx = KEY_LEFT;  end
        SC_ARROW_RIGHT: begin hit = 1'b1; idx = KEY_RIGHT; end
        SC_ARROW_UP:    begin hit = 1'b1; idx = KEY_UP;    end
        SC_ARROW_DOWN:  begin hit = 1'b1; idx = KEY_DOWN;  end
        default:        ;
      endcase
    end else begin
      unique case (code)
        SC_A:     begin hit = 1'b1; idx = KEY_LEFT;  end
        SC_D:     begin hit = 1'b1; idx = KEY_RIGHT; end
        SC_W:     begin hit = 1'b1; idx = KEY_UP;    end
        SC_S:     begin hit = 1'b1; idx = KEY_DOWN;  end
        SC_SPACE: begin hit = 1'b1; idx = KEY_JUMP;  end
        SC_LCTRL: begin hit = 1'b1; idx = KEY_FIRE;  end
        SC_ENTER: begin hit = 1'b1; idx = KEY_ENTER; end
        SC_ESC:   begin hit = 1'b1; idx = KEY_ESC;   end
        default:  ;
      endcase
    end
  end

endmodule

// File: rtl/ps2_key_decoder.sv
// ps2_key_decoder
// Turns the PS/2 receiver byte stream into key events and a pressed-key
// vector, handling E0 (extended), F0 (break) and E1 (pause) prefixes.
//   clk  in : system clock
//   rst  in : synchronous active-high reset
//   bus     : ps2_key_decoder_if.slave (ready_in/data_in in; keys, ev_* out)
// Parameter TIMEOUT_CYCLES: idle cycles after which a pending prefix is dropped.
module ps2_key_decoder
  import ps2_keys_pkg::*;
#(
  parameter int unsigned TIMEOUT_CYCLES = 2_000_000
) (
  input  logic             clk,
  input  logic             rst,
  ps2_key_decoder_if.slave bus
);

  localparam int TW = $clog2(TIMEOUT_CYCLES + 1);
  localparam logic [TW-1:0] TMO_MAX = TW'(TIMEOUT_CYCLES);

  state_t        state_q, state_d;
  logic          rdy_q;
  logic [2:0]    skip_q, skip_d;
  logic [TW-1:0] tmo_q, tmo_d;
  logic [7:0]    keys_q, keys_d;
  logic          ev_valid_q, ev_valid_d;
  logic [7:0]    ev_code_q, ev_code_d;
  logic          ev_ext_q, ev_ext_d;
  logic          ev_break_q, ev_break_d;
  logic          ev_repeat_q, ev_repeat_d;

  logic          accept;
  logic          map_ext;
  logic          map_hit;
  logic [2:0]    map_idx;
  logic          emit;
  logic          emit_break;

  // One accept per rising edge of ready_in, however long the level is held
  assign accept = bus.ready_in & ~rdy_q;

  // An event completed in EXT/EXTBRK is extended; in IDLE/BRK it is not
  assign map_ext = (state_q == ST_EXT) || (state_q == ST_EXTBRK);

  ps2_keymap u_keymap (
    .ext  (map_ext),
    .code (bus.data_in),
    .hit  (map_hit),
    .idx  (map_idx)
  );

  always_comb begin
    state_d     = state_q;
    skip_d      = skip_q;
    tmo_d       = tmo_q;
    keys_d      = keys_q;
    ev_valid_d  = 1'b0;
    ev_code_d   = ev_code_q;
    ev_ext_d    = ev_ext_q;
    ev_break_d  = ev_break_q;
    ev_repeat_d = ev_repeat_q;
    emit        = 1'b0;
    emit_break  = 1'b0;

    if (accept) begin
      // An accept beats a coinciding timeout: the byte is decoded in the
      // current state and the idle counter restarts.
      tmo_d = '0;
      unique case (state_q)
        ST_IDLE: begin
          if (bus.data_in == SC_E0) begin
            state_d = ST_EXT;
          end else if (bus.data_in == SC_F0) begin
            state_d = ST_BRK;
          end else if (bus.data_in == SC_E1) begin
            state_d = ST_SKIP;
            skip_d  = SKIP_LEN;
          end else if (!is_ignored(bus.data_in)) begin
            emit = 1'b1;
          end
        end
        ST_EXT: begin
          if (bus.data_in == SC_F0) begin
            state_d = ST_EXTBRK;
          end else if (bus.data_in == SC_E0) begin
            state_d = ST_EXT;
          end else if (is_fake_shift(bus.data_in)) begin
            state_d = ST_IDLE;
          end else begin
            emit    = 1'b1;
            state_d = ST_IDLE;
          end
        end
        ST_BRK: begin
          emit       = 1'b1;
          emit_break = 1'b1;
          state_d    = ST_IDLE;
        end
        ST_EXTBRK: begin
          state_d = ST_IDLE;
          if (!is_fake_shift(bus.data_in)) begin
            emit       = 1'b1;
            emit_break = 1'b1;
          end
        end
        ST_SKIP: begin
          skip_d = skip_q - 3'd1;
          if (skip_q <= 3'd1) begin
            skip_d  = 3'd0;
            state_d = ST_IDLE;
          end
        end
        default: state_d = ST_IDLE;
      endcase
    end else if (state_q != ST_IDLE) begin
      if (tmo_q == TMO_MAX) begin
        state_d = ST_IDLE;
        skip_d  = 3'd0;
        tmo_d   = '0;
      end else begin
        tmo_d = tmo_q + TW'(1);
      end
    end else begin
      tmo_d = '0;
    end

    if (emit) begin
      ev_valid_d  = 1'b1;
      ev_code_d   = bus.data_in;
      ev_ext_d    = map_ext;
      ev_break_d  = emit_break;
      ev_repeat_d = !emit_break && map_hit && keys_q[map_idx];
      if (map_hit) begin
        keys_d[map_idx] = !emit_break;
      end
    end
  end

  always_ff @(posedge clk) begin
    if (rst) begin
      state_q     <= ST_IDLE;
      rdy_q       <= 1'b0;
      skip_q      <= 3'd0;
      tmo_q       <= '0;
      keys_q      <= 8'h00;
      ev_valid_q  <= 1'b0;
      ev_code_q   <= 8'h00;
      ev_ext_q    <= 1'b0;
      ev_break_q  <= 1'b0;
      ev_repeat_q <= 1'b0;
    end else begin
      state_q     <= state_d;
      rdy_q       <= bus.ready_in;
      skip_q      <= skip_d;
      tmo_q       <= tmo_d;
      keys_q      <= keys_d;
      ev_valid_q  <= ev_valid_d;
      ev_code_q   <= ev_code_d;
      ev_ext_q    <= ev_ext_d;
      ev_break_q  <= ev_break_d;
      ev_repeat_q <= ev_repeat_d;
    end
  end

  assign bus.keys      = keys_q;
  assign bus.ev_valid  = ev_valid_q;
  assign bus.ev_code   = ev_code_q;
  assign bus.ev_ext    = ev_ext_q;
  assign bus.ev_break  = ev_break_q;
  assign bus.ev_repeat = ev_repeat_q;

endmodule

// File: tb/tb_ps2_key_decoder.sv
// tb_ps2_key_decoder
// Scoreboard bench: stimulus pushes expected events into a queue, a monitor
// pops and compares whenever ev_valid is seen. Direct checks cover keys at
// quiet points, reset values and the absence of leftover events.
module tb_ps2_key_decoder;

  localparam int unsigned TMO = 40;

  typedef struct packed {
    logic [7:0] code;
    logic       ext;
    logic       brk;
    logic       rep;
    logic [7:0] keys;
  } exp_t;

  logic clk = 1'b0;
  logic rst = 1'b1;
  int   n_cmp  = 0;
  int   n_fail = 0;
  exp_t exp_q[$];

  ps2_key_decoder_if bus ();

  ps2_key_decoder #(.TIMEOUT_CYCLES(TMO)) dut (
    .clk (clk),
    .rst (rst),
    .bus (bus)
  );

  always #5 clk = ~clk;

  task automatic check8(input string name, input logic [7:0] act, input logic [7:0] exp);
    n_cmp++;
    if (act !== exp) begin
      n_fail++;
      $display("FAIL %s: got %02h expected %02h", name, act, exp);
    end
  endtask

  task automatic expect_ev(input logic [7:0] code, input logic ext, input logic brk,
                           input logic rep, input logic [7:0] keys);
    exp_t e;
    e.code = code; e.ext = ext; e.brk = brk; e.rep = rep; e.keys = keys;
    exp_q.push_back(e);
  endtask

  task automatic monitor_loop();
    exp_t e;
    forever begin
      @(negedge clk);
      if (!rst && bus.ev_valid) begin
        n_cmp++;
        $display("EV code=%02h ext=%0d brk=%0d rep=%0d keys=%02h",
                 bus.ev_code, bus.ev_ext, bus.ev_break, bus.ev_repeat, bus.keys);
        if (exp_q.size() == 0) begin
          n_fail++;
          $display("FAIL unexpected_event: got code=%02h ext=%0d brk=%0d expected no event",
                   bus.ev_code, bus.ev_ext, bus.ev_break);
        end else begin
          e = exp_q.pop_front();
          if (bus.ev_code !== e.code || bus.ev_ext !== e.ext || bus.ev_break !== e.brk ||
              bus.ev_repeat !== e.rep || bus.keys !== e.keys) begin
            n_fail++;
            $display("FAIL event: got code=%02h ext=%0d brk=%0d rep=%0d keys=%02h expected code=%02h ext=%0d brk=%0d rep=%0d keys=%02h",
                     bus.ev_code, bus.ev_ext, bus.ev_break, bus.ev_repeat, bus.keys,
                     e.code, e.ext, e.brk, e.rep, e.keys);
          end
        end
      end
    end
  endtask

  // Present a byte with ready held high for 'hold' cycles, then low for 2
  task automatic send_hold(input logic [7:0] b, input int hold);
    @(posedge clk); #1;
    bus.data_in  = b;
    bus.ready_in = 1'b1;
    repeat (hold) @(posedge clk);
    #1 bus.ready_in = 1'b0;
    repeat (2) @(posedge clk);
  endtask

  task automatic send(input logic [7:0] b);
    send_hold(b, 2);
  endtask

  initial begin
    bus.ready_in = 1'b0;
    bus.data_in  = 8'h00;
    fork
      monitor_loop();
    join_none

    repeat (3) @(posedge clk);
    #1 rst = 1'b0;
    @(negedge clk);
    check8("reset_keys", bus.keys, 8'h00);
    check8("reset_ev_valid", {7'd0, bus.ev_valid}, 8'h00);
    check8("reset_ev_code", bus.ev_code, 8'h00);
    check8("reset_ev_flags", {5'd0, bus.ev_ext, bus.ev_break, bus.ev_repeat}, 8'h00);

    // A press and release
    expect_ev(8'h1C, 0, 0, 0, 8'h01); send(8'h1C);
    expect_ev(8'h1C, 0, 1, 0, 8'h00); send(8'hF0); send(8'h1C);

    // Extended right arrow, typematic repeat, extended release
    expect_ev(8'h74, 1, 0, 0, 8'h02); send(8'hE0); send(8'h74);
    expect_ev(8'h74, 1, 0, 1, 8'h02); send(8'hE0); send(8'h74);
    expect_ev(8'h74, 1, 1, 0, 8'h00); send(8'hE0); send(8'hF0); send(8'h74);

    // Fake shift dropped, status bytes ignored
    expect_ev(8'h75, 1, 0, 0, 8'h04);
    send(8'hE0); send(8'h12); send(8'hE0); send(8'h75);
    send(8'hAA); send(8'hFA);
    @(negedge clk);
    check8("keys_after_up", bus.keys, 8'h04);
    expect_ev(8'h75, 1, 1, 0, 8'h00); send(8'hE0); send(8'hF0); send(8'h75);

    // Pause sequence swallowed, then space
    send(8'hE1); send(8'h14); send(8'h77); send(8'hE1);
    send(8'hF0); send(8'h14); send(8'hF0); send(8'h77);
    @(negedge clk);
    check8("keys_after_pause", bus.keys, 8'h00);
    expect_ev(8'h29, 0, 0, 0, 8'h10); send(8'h29);
    expect_ev(8'h29, 0, 1, 0, 8'h00); send(8'hF0); send(8'h29);

    // Break prefix abandoned after timeout: next byte is a make
    send(8'hF0);
    repeat (TMO + 20) @(posedge clk);
    expect_ev(8'h29, 0, 0, 0, 8'h10); send(8'h29);
    // Break prefix within the timeout still completes
    send(8'hF0);
    repeat (TMO / 2) @(posedge clk);
    expect_ev(8'h29, 0, 1, 0, 8'h00); send(8'h29);

    // Unmapped codes: events, no keys change, never repeat
    expect_ev(8'h33, 0, 0, 0, 8'h00); send(8'h33);
    expect_ev(8'h33, 0, 0, 0, 8'h00); send(8'h33);
    // Extended code that only has a non-extended binding
    expect_ev(8'h1C, 1, 0, 0, 8'h00); send(8'hE0); send(8'h1C);

    // Level held high gives exactly one accept
    expect_ev(8'h1D, 0, 0, 0, 8'h04); send_hold(8'h1D, 10);
    expect_ev(8'h1D, 0, 1, 0, 8'h00); send(8'hF0); send(8'h1D);

    // Reset in the middle of E0 F0 releases everything
    expect_ev(8'h1C, 0, 0, 0, 8'h01); send(8'h1C);
    expect_ev(8'h23, 0, 0, 0, 8'h03); send(8'h23);
    send(8'hE0); send(8'hF0);
    @(posedge clk); #1 rst = 1'b1;
    @(posedge clk); #1 rst = 1'b0;
    @(negedge clk);
    check8("keys_after_rst", bus.keys, 8'h00);
    check8("ev_code_after_rst", bus.ev_code, 8'h00);
    expect_ev(8'h76, 0, 0, 0, 8'h80); send(8'h76);

    repeat (5) @(posedge clk);
    @(negedge clk);
    check8("keys_final", bus.keys, 8'h80);
    n_cmp++;
    if (exp_q.size() != 0) begin
      n_fail++;
      $display("FAIL missing_events: got %0d left in queue expected 0", exp_q.size());
    end

    $display("*** SUMMARY: %0d compared / %0d mismatched ***", n_cmp, n_fail);
    $finish;
  end

endmodule
